// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and widths for the front-panel run-control block
package run_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    PAUSED   = 2'd2,
    RESUMING = 2'd3
  } run_state_t;
  localparam int PAUSE_CNT_W = 16;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronizes an active-low pushbutton, debounces it and emits one press pulse per push
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin_n,
  output logic o_press
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_armed;
  logic                   w_s;
  logic                   w_hit;
  logic                   w_done;
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_hit  = r_armed ? !w_s : w_s;
  assign w_done = w_hit && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // shift the raw pin through the synchronizer; reset looks like a released button
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_n};
  // armed: count low cycles to fire; disarmed: count high cycles to re-arm
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
      o_press <= 1'b0;
    end else begin
      r_cnt   <= (w_hit && !w_done) ? r_cnt + 1'b1 : '0;
      r_armed <= w_done ? !r_armed : r_armed;
      o_press <= w_done && r_armed;
    end
endmodule

// File: rtl/run_continue_ctrl.sv
// run_continue_ctrl: Run/Continue pushbutton sequencer for the CPU; pause counter enabled by RUN_CTRL_PAUSE_COUNT_EN
import run_ctrl_pkg::*;
module run_continue_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CNT_W           = 20
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic                   Continue,
  input  logic                   pause_req,
  output logic                   start,
  output logic                   resume,
  output logic                   run_active,
  output logic                   paused,
  output logic [PAUSE_CNT_W-1:0] pause_count
);
  logic       w_run_press;
  logic       w_cont_press;
  run_state_t r_state;
  run_state_t w_next;
  button_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
  ) u_run_db (
    .i_clk(Clk), .i_rst(Reset), .i_pin_n(Run), .o_press(w_run_press)
  );
  button_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
  ) u_cont_db (
    .i_clk(Clk), .i_rst(Reset), .i_pin_n(Continue), .o_press(w_cont_press)
  );
  // next-state: presses not accepted in the current state are simply dropped
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_run_press  ? RUNNING  : IDLE;
      RUNNING:  w_next = pause_req    ? PAUSED   : RUNNING;
      PAUSED:   w_next = w_cont_press ? RESUMING : PAUSED;
      RESUMING: w_next = pause_req    ? RESUMING : RUNNING;
      default:  w_next = IDLE;
    endcase
  end
  // state and registered outputs, all derived from the upcoming state
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_state    <= IDLE;
      start      <= 1'b0;
      resume     <= 1'b0;
      run_active <= 1'b0;
      paused     <= 1'b0;
    end else begin
      r_state    <= w_next;
      start      <= (r_state == IDLE) && w_run_press;
      resume     <= w_next == RESUMING;
      run_active <= w_next != IDLE;
      paused     <= w_next == PAUSED;
    end
`ifdef RUN_CTRL_PAUSE_COUNT_EN
  logic [PAUSE_CNT_W-1:0] r_pause_cnt;
  // count RUNNING->PAUSED transitions, wrapping naturally
  always_ff @(posedge Clk or posedge Reset)
    if (Reset)                                    r_pause_cnt <= '0;
    else if ((r_state == RUNNING) && pause_req)   r_pause_cnt <= r_pause_cnt + 1'b1;
  assign pause_count = r_pause_cnt;
`else
  assign pause_count = '0;
`endif
endmodule

// File: doc/run_continue_ctrl.md
Name: run_continue_ctrl

Overview:
Front-panel run-control responder for the SLC-3 top level. It consumes the active-low Run and Continue pushbuttons, synchronizes and debounces them, and turns each press into a single event. A small FSM sequences the CPU: a start pulse on Run, and a pause/resume handshake with the CPU control FSM on Continue. Sits between the board/bench pushbutton pins and the CPU control unit inside lc3top.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each button synchronizer (min 2)
DEBOUNCE_CYCLES, 1, consecutive synchronized-low cycles required to accept a press; also consecutive high cycles required to re-arm (use 1 in sim, ~500000 on board)
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Run  in  1  pushbutton, active-low, asynchronous to Clk
Continue  in  1  pushbutton, active-low, asynchronous to Clk
pause_req  in  1  CPU FSM is in its PAUSE state and waits for resume; level
start  out  1  one-cycle pulse: CPU begins fetch from current PC
resume  out  1  level: held until CPU drops pause_req
run_active  out  1  high in RUNNING, PAUSED, RESUMING
paused  out  1  high in PAUSED only
pause_count  out  16  number of pauses entered (see Optional Feature)

Behaviour:
- Reset (async, any state): all synchronizer flops = 1 (released button), debounce counters = 0, both debouncers armed, FSM = IDLE; start = 0, resume = 0, run_active = 0, paused = 0, pause_count = 0.
- Debounce per button: s = synchronized pin. While armed, count cycles with s = 0. Reaching DEBOUNCE_CYCLES fires press (1 cycle), disarms, and clears the count. Any s = 1 before that clears the count. While disarmed, count cycles with s = 1; reaching DEBOUNCE_CYCLES re-arms. Holding a button produces exactly one press.
- Latency: edge 0 is the first rising edge sampling the pin low. press is high after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. The FSM output (start or resume) is high after edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: output is high after edge 3.
- FSM states: IDLE, RUNNING, PAUSED, RESUMING. Outputs are registered.
- IDLE: run_press -> RUNNING with start = 1 for exactly one cycle. continue_press is ignored.
- RUNNING: pause_req = 1 -> PAUSED. run_press and continue_press are ignored.
- PAUSED: continue_press -> RESUMING with resume = 1. run_press is ignored.
- RESUMING: resume stays 1 while pause_req = 1. On the first cycle sampling pause_req = 0, go to RUNNING and drop resume in the same transition.
- Simultaneous events:
  - run_press and continue_press in the same cycle in IDLE: run wins; continue is dropped.
  - pause_req rising and continue_press in the same cycle in RUNNING: go to PAUSED; the press is dropped (never queued).
- Only Reset returns the FSM to IDLE. Reset mid-RESUMING drops resume asynchronously.
- A press that fires while ignored is consumed; it does not fire again later.

Optional Feature:
- Macro: RUN_CTRL_PAUSE_COUNT_EN.
- Defined: pause_count increments by 1 on every RUNNING->PAUSED transition and wraps 16'hFFFF -> 16'h0000.
- Undefined: pause_count is tied to 16'h0000, and no counter flops are generated.

Decomposition:
- Package run_ctrl_pkg: enum typedef run_state_t {IDLE, RUNNING, PAUSED, RESUMING} with a 2-bit encoding, and a localparam PAUSE_CNT_W = 16.
- One sub-module, button_debounce (synchronizer + debounce + press pulse, parameterized SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W), instantiated twice.

Test Plan:
- Reset held 2 cycles with Run = 0 → all outputs 0, state IDLE. Release Reset with Run = 1 → no start.
- Run low for one clock at defaults → start high for exactly one cycle, after edge 3; run_active = 1 thereafter. Hold Run low 20 cycles → still a single start.
- In RUNNING, raise pause_req → paused = 1 next cycle. Pulse Continue low one clock → resume = 1 after edge 3. Hold pause_req 5 more cycles → resume stays 1; drop pause_req → resume = 0 and paused = 0 next cycle, state RUNNING.
- Continue pulsed 7 times while RUNNING with pause_req = 0 → no resume, state unchanged. Then pause_req = 1 → PAUSED; no stale resume appears.
- Run and Continue pressed on the same edge in IDLE → start once, resume never.
- With RUN_CTRL_PAUSE_COUNT_EN, 14 pause/resume cycles → pause_count = 16'h000E. Preload the count to 16'hFFFF via 65535 pause cycles (or force), then one more pause → 16'h0000. Assert Reset during RESUMING → resume = 0 immediately, pause_count = 0.
